// File: rtl/ext_neg_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : ext_neg_pipe
//  Description : Two-stage pipelined immediate extender / negator with a
//                valid/ready handshake on both sides, a negation-overflow
//                flag, and a saturating overflow event counter.
//                Optional build macro: EXT_NEG_SAT_EN. When it is defined,
//                an overflowing negation outputs the largest positive value
//                instead of the wrapped result.
//  Revision    : 1.0 - initial release
// ============================================================================
module ext_neg_pipe #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic             in_sext,
    input  logic             in_neg,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] ovf_cnt
);

    // Most negative OUT_W value: the only input whose negation is not
    // representable.
    localparam logic [OUT_W-1:0] c_min_neg = {1'b1, {(OUT_W-1){1'b0}}};
    // Largest positive OUT_W value, used as the clamped negation result.
    localparam logic [OUT_W-1:0] c_max_pos = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    // Stage 1: extended operand plus the pending negate request.
    logic             r_s1_full;
    logic [OUT_W-1:0] r_s1_ext;
    logic             r_s1_neg;

    // Stage 2: final result, which is also the output register.
    logic             r_s2_full;
    logic [OUT_W-1:0] r_out_data;
    logic             r_out_ovf;
    logic [CNT_W-1:0] r_ovf_cnt;

    logic             w_s2_adv;
    logic             w_s1_adv;
    logic             w_out_xfer;
    logic [IN_W-1:0]  w_imm_inv;
    logic [OUT_W-1:0] w_ext;
    logic [OUT_W-1:0] w_neg_val;
    logic             w_ovf;
    logic [OUT_W-1:0] w_res;

    // A stage may load when it is empty or when its content moves on in the
    // same edge, so a full pipe streams one beat per cycle with no bubble.
    assign w_s2_adv   = !r_s2_full || out_ready;
    assign w_s1_adv   = !r_s1_full || w_s2_adv;
    assign w_out_xfer = r_s2_full && out_ready;

    assign in_ready  = w_s1_adv;
    assign out_valid = r_s2_full;
    assign out_data  = r_out_data;
    assign out_ovf   = r_out_ovf;
    assign ovf_cnt   = r_ovf_cnt;

    // Sign extension without a zero-width replication: for a negative
    // immediate, complementing the zero-extended complement of the immediate
    // fills every upper bit with ones. This also covers IN_W == OUT_W.
    assign w_imm_inv = ~in_imm;
    assign w_ext     = (in_sext && in_imm[IN_W-1]) ? ~(OUT_W'(w_imm_inv))
                                                   : OUT_W'(in_imm);

    // Two's-complement negation; the most negative value maps onto itself
    // and is reported as overflow.
    assign w_neg_val = ~r_s1_ext + OUT_W'(1);
    assign w_ovf     = r_s1_neg && (r_s1_ext == c_min_neg);

`ifdef EXT_NEG_SAT_EN
    assign w_res = w_ovf ? c_max_pos : (r_s1_neg ? w_neg_val : r_s1_ext);
`else
    assign w_res = r_s1_neg ? w_neg_val : r_s1_ext;
`endif

    // Stage 1 load: capture the extended immediate on an accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_full <= 1'b0;
            r_s1_ext  <= '0;
            r_s1_neg  <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_full <= in_valid;
            if (in_valid) begin
                r_s1_ext <= w_ext;
                r_s1_neg <= in_neg;
            end
        end
    end

    // Stage 2 load: register the negated/overflow-checked result; it holds
    // steady while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_full  <= 1'b0;
            r_out_data <= '0;
            r_out_ovf  <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_full <= r_s1_full;
            if (r_s1_full) begin
                r_out_data <= w_res;
                r_out_ovf  <= w_ovf;
            end
        end
    end

    // Overflow event counter: counts delivered overflow results, saturates
    // at all-ones, and a clear wins over a simultaneous increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf_cnt <= '0;
        end else if (cnt_clr) begin
            r_ovf_cnt <= '0;
        end else if (w_out_xfer && r_out_ovf && (r_ovf_cnt != c_cnt_max)) begin
            r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ext_neg_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ext_neg_pipe
//  Description : Self-checking bench for ext_neg_pipe. Instance A uses the
//                12->32 configuration; instance B is 8->8 with a 2-bit
//                counter so that overflow and saturation are reachable.
//                Honours EXT_NEG_SAT_EN in its reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ext_neg_pipe;

    localparam int A_IN = 12, A_OUT = 32, A_CNT = 16;
    localparam int B_IN = 8,  B_OUT = 8,  B_CNT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A ports
    logic             a_in_valid = 0, a_in_ready, a_in_sext = 0, a_in_neg = 0;
    logic [A_IN-1:0]  a_in_imm = '0;
    logic             a_out_valid, a_out_ready = 1, a_out_ovf, a_cnt_clr = 0;
    logic [A_OUT-1:0] a_out_data;
    logic [A_CNT-1:0] a_ovf_cnt;

    // Instance B ports
    logic             b_in_valid = 0, b_in_ready, b_in_sext = 0, b_in_neg = 0;
    logic [B_IN-1:0]  b_in_imm = '0;
    logic             b_out_valid, b_out_ready = 1, b_out_ovf, b_cnt_clr = 0;
    logic [B_OUT-1:0] b_out_data;
    logic [B_CNT-1:0] b_ovf_cnt;

    ext_neg_pipe #(.IN_W(A_IN), .OUT_W(A_OUT), .CNT_W(A_CNT)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_imm(a_in_imm),
        .in_sext(a_in_sext), .in_neg(a_in_neg),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_ovf(a_out_ovf),
        .cnt_clr(a_cnt_clr), .ovf_cnt(a_ovf_cnt)
    );

    ext_neg_pipe #(.IN_W(B_IN), .OUT_W(B_OUT), .CNT_W(B_CNT)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_imm(b_in_imm),
        .in_sext(b_in_sext), .in_neg(b_in_neg),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_ovf(b_out_ovf),
        .cnt_clr(b_cnt_clr), .ovf_cnt(b_ovf_cnt)
    );

    typedef struct { longint data; bit ovf; } res_t;
    typedef struct { longint imm; bit sx; bit ng; longint exp; bit eovf; } vec_t;

    res_t   qa[$], qb[$];
    int     n_cmp = 0, n_bad = 0;
    longint cnt_a = 0, cnt_b = 0;
    bit     a_stall = 0, b_stall = 0, a_hold_o, b_hold_o, a_last_ir;
    longint a_hold_d, b_hold_d;
    int     a_deliv = 0, b_deliv = 0;

`ifdef EXT_NEG_SAT_EN
    localparam longint B_OVF_DATA = 64'h7F;
`else
    localparam longint B_OVF_DATA = 64'h80;
`endif

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Arithmetic reference: take the immediate's numeric value, view it as a
    // signed OUT_W quantity, negate, and wrap (or clamp) into OUT_W bits.
    function automatic void model(input int iw, input int ow, input longint imm,
                                  input bit sx, input bit ng,
                                  output longint data, output bit ovf);
        longint full, half, v;
        full = longint'(1) << ow;
        half = full >> 1;
        v = imm & ((longint'(1) << iw) - 1);
        if (sx && v >= (longint'(1) << (iw - 1))) v = v - (longint'(1) << iw);
        if (v >= half) v = v - full;
        ovf = ng && (v == -half);
        if (ng) v = -v;
`ifdef EXT_NEG_SAT_EN
        if (ovf) v = half - 1;
`endif
        data = v & (full - 1);
    endfunction

    // One clock of instance A, entered and left at a falling edge.
    task automatic cycle_a(input bit v, input longint imm, input bit sx, input bit ng,
                           input bit rdy, input bit clr, output bit acc);
        res_t r;
        if (a_out_valid) begin
            chk("a_unexpected_valid", longint'(qa.size() > 0), 1);
            if (qa.size() > 0) begin
                chk("a_data", a_out_data, qa[0].data);
                chk("a_ovf", a_out_ovf, qa[0].ovf);
            end
        end
        if (a_stall) begin
            chk("a_hold_valid", a_out_valid, 1);
            chk("a_hold_data", a_out_data, a_hold_d);
            chk("a_hold_ovf", a_out_ovf, a_hold_o);
        end
        chk("a_cnt", a_ovf_cnt, cnt_a);
        a_in_valid = v; a_in_imm = imm[A_IN-1:0]; a_in_sext = sx; a_in_neg = ng;
        a_out_ready = rdy; a_cnt_clr = clr;
        #1;
        a_last_ir = a_in_ready;
        acc = v && a_in_ready;
        if (a_out_valid && rdy && qa.size() > 0) begin
            r = qa.pop_front();
            a_deliv++;
            if (r.ovf && cnt_a < (longint'(1) << A_CNT) - 1) cnt_a++;
        end
        if (clr) cnt_a = 0;
        if (acc) begin
            model(A_IN, A_OUT, imm, sx, ng, r.data, r.ovf);
            qa.push_back(r);
        end
        a_stall = a_out_valid && !rdy;
        a_hold_d = a_out_data;
        a_hold_o = a_out_ovf;
        @(negedge clk);
    endtask

    // One clock of instance B, entered and left at a falling edge.
    task automatic cycle_b(input bit v, input longint imm, input bit sx, input bit ng,
                           input bit rdy, input bit clr, output bit acc);
        res_t r;
        if (b_out_valid) begin
            chk("b_unexpected_valid", longint'(qb.size() > 0), 1);
            if (qb.size() > 0) begin
                chk("b_data", b_out_data, qb[0].data);
                chk("b_ovf", b_out_ovf, qb[0].ovf);
            end
        end
        if (b_stall) begin
            chk("b_hold_valid", b_out_valid, 1);
            chk("b_hold_data", b_out_data, b_hold_d);
            chk("b_hold_ovf", b_out_ovf, b_hold_o);
        end
        chk("b_cnt", b_ovf_cnt, cnt_b);
        b_in_valid = v; b_in_imm = imm[B_IN-1:0]; b_in_sext = sx; b_in_neg = ng;
        b_out_ready = rdy; b_cnt_clr = clr;
        #1;
        acc = v && b_in_ready;
        if (b_out_valid && rdy && qb.size() > 0) begin
            r = qb.pop_front();
            b_deliv++;
            if (r.ovf && cnt_b < (longint'(1) << B_CNT) - 1) cnt_b++;
        end
        if (clr) cnt_b = 0;
        if (acc) begin
            model(B_IN, B_OUT, imm, sx, ng, r.data, r.ovf);
            qb.push_back(r);
        end
        b_stall = b_out_valid && !rdy;
        b_hold_d = b_out_data;
        b_hold_o = b_out_ovf;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv[7];
        bit   acc, saw_ir_low;
        int   sent, d0, c;

        tv[0] = '{64'h005, 1'b1, 1'b0, 64'h00000005, 1'b0};
        tv[1] = '{64'hFFB, 1'b1, 1'b0, 64'hFFFFFFFB, 1'b0};
        tv[2] = '{64'h539, 1'b1, 1'b1, 64'hFFFFFAC7, 1'b0};
        tv[3] = '{64'hFFB, 1'b1, 1'b1, 64'h00000005, 1'b0};
        tv[4] = '{64'h81D, 1'b1, 1'b0, 64'hFFFFF81D, 1'b0};
        tv[5] = '{64'h81D, 1'b0, 1'b0, 64'h0000081D, 1'b0};
        tv[6] = '{64'h81D, 1'b0, 1'b1, 64'hFFFFF7E3, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_data", a_out_data, 0);
        chk("rst_out_ovf", a_out_ovf, 0);
        chk("rst_ovf_cnt", a_ovf_cnt, 0);
        chk("rst_in_ready", a_in_ready, 1);
        chk("rst_b_in_ready", b_in_ready, 1);
        @(negedge clk);

        // Directed vectors: latency and values
        foreach (tv[i]) begin
            cycle_a(1, tv[i].imm, tv[i].sx, tv[i].ng, 1, 0, acc);
            chk("tv_accept", acc, 1);
            chk("tv_lat_s1", a_out_valid, 0);
            cycle_a(0, 0, 0, 0, 1, 0, acc);
            chk("tv_lat_s2", a_out_valid, 1);
            chk("tv_data", a_out_data, tv[i].exp);
            chk("tv_ovf", a_out_ovf, tv[i].eovf);
            cycle_a(0, 0, 0, 0, 1, 0, acc);
            chk("tv_drained", a_out_valid, 0);
        end

        // Six back-to-back beats, consumer stalled for cycles 3..6
        sent = 0; saw_ir_low = 0; d0 = a_deliv; c = 1;
        while ((sent < 6 || qa.size() > 0) && c < 40) begin
            cycle_a(sent < 6, longint'($urandom), $urandom_range(0, 1), $urandom_range(0, 1),
                    !(c >= 3 && c <= 6), 0, acc);
            if (c >= 3 && c <= 6 && !a_last_ir) saw_ir_low = 1;
            if (c == 7) chk("bp_release_in_ready", a_last_ir, 1);
            if (acc) sent++;
            c++;
        end
        chk("bp_in_ready_dropped", saw_ir_low, 1);
        chk("bp_delivered", a_deliv - d0, 6);
        chk("bp_queue_empty", qa.size(), 0);

        // Reset with two beats in flight
        cycle_a(1, 64'h123, 1, 0, 0, 0, acc);
        cycle_a(1, 64'h456, 0, 1, 0, 0, acc);
        chk("mid_valid_before", a_out_valid, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", a_out_valid, 0);
        chk("mid_rst_data", a_out_data, 0);
        chk("mid_rst_ovf", a_out_ovf, 0);
        qa.delete(); qb.delete(); cnt_a = 0; cnt_b = 0; a_stall = 0; b_stall = 0;
        a_in_valid = 0; b_in_valid = 0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_post_in_ready", a_in_ready, 1);
        @(negedge clk);
        repeat (4) cycle_a(0, 0, 0, 0, 1, 0, acc);

        // Instance B: single overflow beat
        cycle_b(1, 64'h80, 0, 1, 1, 0, acc);
        chk("b_ovf_accept", acc, 1);
        cycle_b(0, 0, 0, 0, 1, 0, acc);
        chk("b_ovf_valid", b_out_valid, 1);
        chk("b_ovf_data", b_out_data, B_OVF_DATA);
        chk("b_ovf_flag", b_out_ovf, 1);
        cycle_b(0, 0, 0, 0, 1, 0, acc);
        chk("b_cnt_one", b_ovf_cnt, 1);

        // Five more overflow beats: counter sticks at 3
        for (int i = 0; i < 5; i++) cycle_b(1, 64'h80, 1, 1, 1, 0, acc);
        repeat (3) cycle_b(0, 0, 0, 0, 1, 0, acc);
        chk("b_cnt_sat", b_ovf_cnt, 3);

        // Clear in the same cycle as an overflow delivery
        cycle_b(1, 64'h80, 1, 1, 0, 0, acc);
        cycle_b(0, 0, 0, 0, 0, 0, acc);
        chk("b_clr_pending", b_out_valid, 1);
        cycle_b(0, 0, 0, 0, 1, 1, acc);
        chk("b_clr_wins", b_ovf_cnt, 0);
        cycle_b(0, 0, 0, 0, 1, 0, acc);

        // Randomised traffic on both instances against the reference model
        for (int i = 0; i < 300; i++) begin
            cycle_b($urandom_range(0, 3) != 0,
                    ($urandom_range(0, 3) == 0) ? 64'h80 : longint'($urandom),
                    $urandom_range(0, 1), $urandom_range(0, 1),
                    $urandom_range(0, 9) < 7, $urandom_range(0, 31) == 0, acc);
        end
        for (int i = 0; i < 10 && qb.size() > 0; i++) cycle_b(0, 0, 0, 0, 1, 0, acc);
        chk("b_rand_drained", qb.size(), 0);

        for (int i = 0; i < 200; i++) begin
            cycle_a($urandom_range(0, 3) != 0, longint'($urandom),
                    $urandom_range(0, 1), $urandom_range(0, 1),
                    $urandom_range(0, 9) < 7, $urandom_range(0, 31) == 0, acc);
        end
        for (int i = 0; i < 10 && qa.size() > 0; i++) cycle_a(0, 0, 0, 0, 1, 0, acc);
        chk("a_rand_drained", qa.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
